// File: rtl/fetch_unit.sv
// fetch_unit: fetch-stage PC generator with an optional direct-mapped BTB.
// Define BRANCH_PREDICT_EN to build the 2-bit saturating counter predictor.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter int          IDX_BITS    = $clog2(BTB_ENTRIES)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall_En,
    input  logic        Redirect_E,
    input  logic [31:0] Redirect_PC_E,
    input  logic        Branch_E,
    input  logic        Taken_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] Target_E,
    output logic [31:0] PC_F,
    output logic [31:0] PC_Plus_4_F,
    output logic        Predict_Taken_F,
    output logic        Valid_F
);
    localparam int TAG_W = 30 - IDX_BITS;

    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_pred;
    logic [29:0] w_pred_tgt;

`ifdef BRANCH_PREDICT_EN
    logic             r_btb_v   [BTB_ENTRIES];
    logic [TAG_W-1:0] r_btb_tag [BTB_ENTRIES];
    logic [29:0]      r_btb_tgt [BTB_ENTRIES];
    logic [1:0]       r_btb_ctr [BTB_ENTRIES];

    logic [IDX_BITS-1:0] w_rd_idx;
    logic [IDX_BITS-1:0] w_wr_idx;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [TAG_W-1:0]    w_wr_tag;
    logic                w_wr_hit;
    logic                w_unused;

    assign w_rd_idx   = r_pc[IDX_BITS+1:2];
    assign w_rd_tag   = r_pc[31:IDX_BITS+2];
    assign w_wr_idx   = PC_E[IDX_BITS+1:2];
    assign w_wr_tag   = PC_E[31:IDX_BITS+2];
    assign w_wr_hit   = r_btb_v[w_wr_idx] && (r_btb_tag[w_wr_idx] == w_wr_tag);
    assign w_pred     = r_btb_v[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag)
                        && r_btb_ctr[w_rd_idx][1];
    assign w_pred_tgt = r_btb_tgt[w_rd_idx];
    assign w_unused   = ^{Redirect_PC_E[1:0], PC_E[1:0], Target_E[1:0]};

    // Tag/target need no reset: they are only read behind the valid bit.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_v[i]   <= 1'b0;
                r_btb_ctr[i] <= 2'b01;
            end
        end else if (Branch_E) begin
            if (w_wr_hit) begin
                if (Taken_E) begin
                    if (r_btb_ctr[w_wr_idx] != 2'b11)
                        r_btb_ctr[w_wr_idx] <= r_btb_ctr[w_wr_idx] + 2'b01;
                    r_btb_tgt[w_wr_idx] <= Target_E[31:2];
                end else if (r_btb_ctr[w_wr_idx] != 2'b00) begin
                    r_btb_ctr[w_wr_idx] <= r_btb_ctr[w_wr_idx] - 2'b01;
                end
            end else begin
                r_btb_v[w_wr_idx]   <= 1'b1;
                r_btb_tag[w_wr_idx] <= w_wr_tag;
                r_btb_tgt[w_wr_idx] <= Target_E[31:2];
                r_btb_ctr[w_wr_idx] <= Taken_E ? 2'b10 : 2'b01;
            end
        end
    end
`else
    logic w_unused;

    assign w_pred     = 1'b0;
    assign w_pred_tgt = '0;
    assign w_unused   = ^{Redirect_PC_E[1:0], Branch_E, Taken_E, PC_E, Target_E};
`endif

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (Redirect_E)
            w_next_pc = {Redirect_PC_E[31:2], 2'b00};
        else if (Stall_En)
            w_next_pc = r_pc;
        else if (w_pred)
            w_next_pc = {w_pred_tgt, 2'b00};
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b1;
        end
    end

    assign PC_F            = r_pc;
    assign PC_Plus_4_F     = w_pc_plus4;
    assign Predict_Taken_F = w_pred;
    assign Valid_F         = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus against a table-level model
// of the fetch PC and BTB.
module tb_fetch_unit;
    logic        CLK = 1'b0;
    logic        RST, Stall_En, Redirect_E, Branch_E, Taken_E;
    logic [31:0] Redirect_PC_E, PC_E, Target_E;
    logic [31:0] PC_F, PC_Plus_4_F;
    logic        Predict_Taken_F, Valid_F;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK(CLK), .RST(RST), .Stall_En(Stall_En), .Redirect_E(Redirect_E),
        .Redirect_PC_E(Redirect_PC_E), .Branch_E(Branch_E), .Taken_E(Taken_E),
        .PC_E(PC_E), .Target_E(Target_E), .PC_F(PC_F), .PC_Plus_4_F(PC_Plus_4_F),
        .Predict_Taken_F(Predict_Taken_F), .Valid_F(Valid_F)
    );

`ifdef BRANCH_PREDICT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: architectural PC plus a 16-entry table keyed by (pc/4)%16
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_known = 1'b0;
    bit          mv   [16];
    logic [31:0] mtag [16];
    logic [31:0] mtgt [16];
    int          mctr [16];

    function automatic int idx_of(logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic bit m_hit(logic [31:0] a);
        int i = idx_of(a);
        return mv[i] && (mtag[i] == a / 64);
    endfunction

    function automatic bit m_pred();
        return BP && m_hit(m_pc) && (mctr[idx_of(m_pc)] >= 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mv[i]   = 1'b0;
            mctr[i] = 1;
        end
    endtask

    task automatic cyc(input bit rst, input bit stall, input bit redir,
                       input logic [31:0] rpc, input bit br, input bit tk,
                       input logic [31:0] pce, input logic [31:0] tgt);
        logic [31:0] nxt;
        bit p;
        int i;
        RST = rst; Stall_En = stall; Redirect_E = redir; Redirect_PC_E = rpc;
        Branch_E = br; Taken_E = tk; PC_E = pce; Target_E = tgt;
        #1;
        p = m_pred();
        if (m_known) begin
            chk("pc", PC_F, m_pc);
            chk("pc4", PC_Plus_4_F, m_pc + 32'd4);
            chk("pred", {31'b0, Predict_Taken_F}, {31'b0, p});
            chk("valid", {31'b0, Valid_F}, {31'b0, m_valid});
        end
        if (!rst) begin
            m_reset();
        end else begin
            if (redir)      nxt = rpc & ~32'd3;
            else if (stall) nxt = m_pc;
            else if (p)     nxt = mtgt[idx_of(m_pc)] & ~32'd3;
            else            nxt = m_pc + 32'd4;
            if (BP && br) begin
                i = idx_of(pce);
                if (m_hit(pce)) begin
                    if (tk) begin
                        mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
                        mtgt[i] = tgt;
                    end else begin
                        mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
                    end
                end else begin
                    mv[i]   = 1'b1;
                    mtag[i] = pce / 64;
                    mtgt[i] = tgt;
                    mctr[i] = tk ? 2 : 1;
                end
            end
            m_pc    = nxt;
            m_valid = 1'b1;
        end
        m_known = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] pce, input bit tk, input logic [31:0] tgt);
        cyc(1, 0, 0, 0, 1, tk, pce, tgt);
    endtask

    task automatic jump(input logic [31:0] a);
        cyc(1, 0, 1, a, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", PC_F, 32'h0);
        chk("rst_valid", {31'b0, Valid_F}, 32'h0);
        run(4);
        chk("seq_pc", PC_F, 32'h10);
        for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("stall_hold", PC_F, 32'h10);
        chk("stall_valid", {31'b0, Valid_F}, 32'h1);
        run(1);
        chk("resume", PC_F, 32'h14);
        cyc(1, 1, 1, 32'h0000_0203, 0, 0, 0, 0);
        chk("redir_wins", PC_F, 32'h200);
        train(32'h40, 1, 32'h100);
        jump(32'h38);
        run(2);
        chk("at_40", PC_F, 32'h40);
        chk("pred_40", {31'b0, Predict_Taken_F}, {31'b0, BP});
        run(1);
        chk("tgt_jump", PC_F, BP ? 32'h100 : 32'h44);
        train(32'h40, 0, 32'h0);
        train(32'h40, 0, 32'h0);
        train(32'h40, 0, 32'h0);
        jump(32'h40);
        chk("nt_pred", {31'b0, Predict_Taken_F}, 32'h0);
        run(1);
        train(32'h40, 1, 32'h180);
        train(32'h40, 1, 32'h180);
        jump(32'h40);
        chk("retrain", {31'b0, Predict_Taken_F}, {31'b0, BP});
        run(1);
        jump(32'hFFFF_FFFC);
        chk("wrap_pc4", PC_Plus_4_F, 32'h0);
        run(1);
        chk("wrap_pc", PC_F, 32'h0);
        cyc(0, 1, 1, 32'h500, 1, 1, 32'h40, 32'h300);
        chk("mid_rst_pc", PC_F, 32'h0);
        chk("mid_rst_valid", {31'b0, Valid_F}, 32'h0);
        jump(32'h40);
        chk("rst_miss", {31'b0, Predict_Taken_F}, 32'h0);
        run(2);
        for (int k = 0; k < 600; k++) begin
            logic [31:0] pce, tgt, rpc;
            pce = ($urandom_range(0, 1) << 10) | ($urandom_range(0, 31) << 2);
            tgt = $urandom_range(0, 255) << 2;
            rpc = $urandom_range(0, 511);
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 19) == 0), rpc,
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1), pce, tgt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
